conv_engine_param: RTL and testbench
====================================

CONV_ENGINE_PARAM -- requirements
Module: conv_engine_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning SRAM word width and signed element width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning SRAM address width.
REQ-003 SHALL have parameter KDIM, default 3, legal range 2..5, meaning the kernel is KDIM x KDIM.
REQ-004 SHALL have parameter MAX_DIM, default 32, meaning the largest accepted matrix dimension N.
REQ-005 SHALL have parameter RELU_EN, default 1, meaning 1 clamps negative results to 0 and 0 passes signed results.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port dut_run, input, 1 bit: run request.
REQ-009 SHALL have port dut_busy, output, 1 bit: high while a run is in progress.
REQ-010 SHALL have port input_sram_read_address, output, ADDR_WIDTH bits: input matrix read address.
REQ-011 SHALL have port input_sram_read_data, input, DATA_WIDTH bits: input SRAM data, valid one cycle after the address.
REQ-012 SHALL have port weights_sram_read_address, output, ADDR_WIDTH bits: kernel read address.
REQ-013 SHALL have port weights_sram_read_data, input, DATA_WIDTH bits: weight data, one-cycle read latency.
REQ-014 SHALL have port output_sram_write_enable, output, 1 bit: output write strobe.
REQ-015 SHALL have port output_sram_write_addresss, output, ADDR_WIDTH bits: output write address.
REQ-016 SHALL have port output_sram_write_data, output, DATA_WIDTH bits: output write data.

Function
REQ-017 SHALL load KDIM*KDIM signed weights, row-major from weight address 0, once per run into internal registers; one weight set is used for every matrix in the run.
REQ-018 SHALL treat input memory as a sequence of records: word at base = N, followed by N*N signed elements row-major; the first record is at base 0 and the next is at base+1+N*N.
REQ-019 SHALL end the run when N == all-ones (sentinel) or N > MAX_DIM; neither case writes anything.
REQ-020 SHALL skip a record with N < KDIM, writing nothing and advancing to the next record.
REQ-021 SHALL produce, for each valid record, (N-KDIM+1)^2 outputs in row-major order; each output is the sum over the KDIM x KDIM window of input*weight.
REQ-022 SHALL accumulate at full precision: 2*DATA_WIDTH+ceil(log2(KDIM*KDIM)) bits, signed.
REQ-023 SHALL apply ReLU when RELU_EN=1, then saturate to signed DATA_WIDTH: max 2^(DATA_WIDTH-1)-1, min -2^(DATA_WIDTH-1).
REQ-024 SHALL write outputs contiguously from output address 0 across all records in the run; addresses wrap modulo 2^ADDR_WIDTH.
REQ-025 SHALL use FSM states IDLE -> LOAD_W -> READ_DIM -> CONV -> WRITE -> (CONV | READ_DIM) -> DONE -> IDLE.
REQ-026 SHALL leave IDLE only when dut_run is sampled high in IDLE; dut_busy rises on the next edge.
REQ-027 SHALL ignore dut_run while busy; if dut_run is still high on return to IDLE, a new run starts.
REQ-028 SHALL take no more than KDIM*KDIM+3 cycles per output; SRAM reads are pipelined at one read per cycle.
REQ-029 SHALL assert output_sram_write_enable for exactly one cycle per output; it stays low in all other states.
REQ-030 SHALL drop dut_busy in DONE only after the final write cycle has completed.

Reset
REQ-031 SHALL, on reset, force dut_busy=0, output_sram_write_enable=0, all addresses=0, output_sram_write_data=0, and FSM=IDLE on that same edge, including mid-run.
REQ-032 SHALL leave output words already written before a mid-run reset untouched; after reset, a run restarts from record 0.

Verification
REQ-033 SHALL pass: KDIM=3, N=4, all inputs 1, all weights 1, then sentinel -> exactly four writes of 9 to addresses 0..3; dut_busy then falls.
REQ-034 SHALL pass: the same data with weights all -1 and RELU_EN=1 -> four writes of 0; with RELU_EN=0 -> four writes of 16'hFFF7.
REQ-035 SHALL pass: inputs 16'h7FFF, weights 2, N=3 -> one write of 16'h7FFF (saturated).
REQ-036 SHALL pass: records N=4, N=2, N=3, then sentinel -> five writes at addresses 0..4, with the N=2 record skipped.
REQ-037 SHALL pass: word0 = 16'hFFFF -> dut_busy high for at least one cycle, zero writes, return to IDLE.
REQ-038 SHALL pass: reset asserted for 2 cycles during CONV -> dut_busy=0 and write_enable=0 on the first reset edge; a subsequent dut_run reproduces the full correct output.

Source files
------------

// File: rtl/conv_engine_param.sv
// KDIM x KDIM signed convolution engine over a chain of N x N matrix records in input SRAM.
// Weights are loaded once per run; results are ReLU'd (optionally), saturated and written contiguously.
module conv_engine_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int KDIM       = 3,
  parameter int MAX_DIM    = 32,
  parameter int RELU_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dut_run,
  output logic                  dut_busy,
  output logic [ADDR_WIDTH-1:0] input_sram_read_address,
  input  logic [DATA_WIDTH-1:0] input_sram_read_data,
  output logic [ADDR_WIDTH-1:0] weights_sram_read_address,
  input  logic [DATA_WIDTH-1:0] weights_sram_read_data,
  output logic                  output_sram_write_enable,
  output logic [ADDR_WIDTH-1:0] output_sram_write_addresss,
  output logic [DATA_WIDTH-1:0] output_sram_write_data
);

  localparam int K2    = KDIM * KDIM;
  localparam int CW    = $clog2(K2 + 1);
  localparam int KW    = $clog2(KDIM + 1);
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(K2);

  typedef enum logic [2:0] {IDLE, LOAD_W, READ_DIM, CONV, WRITE, DONE} state_t;

  state_t r_state, w_nextState;

  logic [ADDR_WIDTH-1:0] r_base, r_outAddr, r_row, r_col, r_dim, r_inAddr, r_wAddr;
  logic [CW-1:0]         r_issueCnt, r_capCnt;
  logic [KW-1:0]         r_ki, r_kj;
  logic                  r_v1, r_v2;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [DATA_WIDTH-1:0] r_weights [K2];

  logic                    w_lastCap, w_dimEnd, w_dimSkip, w_lastCol, w_lastRow;
  logic [ADDR_WIDTH-1:0]   w_newDim, w_skipBase, w_nextBase, w_inAddr;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0] w_accNext, w_relu;
  logic [DATA_WIDTH-1:0]   w_sat;

  assign w_lastCap  = r_v2 && (r_capCnt == CW'(K2 - 1));
  assign w_dimEnd   = (input_sram_read_data == '1) || (input_sram_read_data > DATA_WIDTH'(MAX_DIM));
  assign w_dimSkip  = input_sram_read_data < DATA_WIDTH'(KDIM);
  assign w_newDim   = ADDR_WIDTH'(input_sram_read_data);
  assign w_skipBase = r_base + ADDR_WIDTH'(1) + w_newDim * w_newDim;
  assign w_nextBase = r_base + ADDR_WIDTH'(1) + r_dim * r_dim;
  assign w_lastCol  = r_col == (r_dim - ADDR_WIDTH'(KDIM));
  assign w_lastRow  = r_row == (r_dim - ADDR_WIDTH'(KDIM));
  assign w_inAddr   = r_base + ADDR_WIDTH'(1) + (r_row + ADDR_WIDTH'(r_ki)) * r_dim
                      + r_col + ADDR_WIDTH'(r_kj);
  assign w_prod     = $signed(input_sram_read_data) * r_weights[r_capCnt];
  assign w_accNext  = r_acc + {{(ACC_W - 2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  always_comb begin
    w_relu = r_acc;
    if (RELU_EN != 0 && r_acc[ACC_W-1]) w_relu = '0;
    w_sat = w_relu[DATA_WIDTH-1:0];
    if (!w_relu[ACC_W-1] && (w_relu[ACC_W-2:DATA_WIDTH-1] != '0))
      w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (w_relu[ACC_W-1] && (w_relu[ACC_W-2:DATA_WIDTH-1] != '1))
      w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (dut_run) w_nextState = LOAD_W;
      LOAD_W:   if (w_lastCap) w_nextState = READ_DIM;
      READ_DIM: if (r_v2) w_nextState = w_dimEnd ? DONE : (w_dimSkip ? READ_DIM : CONV);
      CONV:     if (w_lastCap) w_nextState = WRITE;
      WRITE:    w_nextState = (w_lastCol && w_lastRow) ? READ_DIM : CONV;
      DONE:     w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  always_comb begin
    dut_busy                   = r_state != IDLE;
    output_sram_write_enable   = r_state == WRITE;
    output_sram_write_data     = (r_state == WRITE) ? w_sat : '0;
    output_sram_write_addresss = r_outAddr;
    input_sram_read_address    = r_inAddr;
    weights_sram_read_address  = r_wAddr;
  end

  // r_v1/r_v2 track a read in flight: data is on the bus the cycle r_v2 is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0; r_outAddr <= '0; r_row <= '0; r_col <= '0; r_dim <= '0;
      r_inAddr <= '0; r_wAddr <= '0; r_issueCnt <= '0; r_capCnt <= '0;
      r_ki <= '0; r_kj <= '0; r_v1 <= 1'b0; r_v2 <= 1'b0; r_acc <= '0;
    end else begin
      r_v1 <= 1'b0;
      r_v2 <= r_v1;
      case (r_state)
        IDLE: begin
          r_base <= '0; r_outAddr <= '0; r_issueCnt <= '0; r_capCnt <= '0;
          r_ki <= '0; r_kj <= '0; r_acc <= '0;
        end
        LOAD_W: begin
          if (r_issueCnt < CW'(K2)) begin
            r_wAddr    <= ADDR_WIDTH'(r_issueCnt);
            r_issueCnt <= r_issueCnt + CW'(1);
            r_v1       <= 1'b1;
          end
          if (r_v2) begin
            r_weights[r_capCnt] <= $signed(weights_sram_read_data);
            r_capCnt            <= r_capCnt + CW'(1);
          end
          if (w_lastCap) begin
            r_issueCnt <= '0;
            r_capCnt   <= '0;
          end
        end
        READ_DIM: begin
          if (r_issueCnt == '0) begin
            r_inAddr   <= r_base;
            r_issueCnt <= CW'(1);
            r_v1       <= 1'b1;
          end
          if (r_v2) begin
            r_issueCnt <= '0;
            if (!w_dimEnd) begin
              if (w_dimSkip) r_base <= w_skipBase;
              else begin
                r_dim <= w_newDim; r_row <= '0; r_col <= '0; r_acc <= '0;
              end
            end
          end
        end
        CONV: begin
          if (r_issueCnt < CW'(K2)) begin
            r_inAddr   <= w_inAddr;
            r_issueCnt <= r_issueCnt + CW'(1);
            r_v1       <= 1'b1;
            if (r_kj == KW'(KDIM - 1)) begin
              r_kj <= '0;
              r_ki <= r_ki + KW'(1);
            end else r_kj <= r_kj + KW'(1);
          end
          if (r_v2) begin
            r_acc    <= w_accNext;
            r_capCnt <= r_capCnt + CW'(1);
          end
          if (w_lastCap) begin
            r_capCnt <= '0; r_issueCnt <= '0; r_ki <= '0; r_kj <= '0;
          end
        end
        WRITE: begin
          r_outAddr <= r_outAddr + ADDR_WIDTH'(1);
          r_acc     <= '0;
          if (w_lastCol) begin
            r_col <= '0;
            if (w_lastRow) begin
              r_row  <= '0;
              r_base <= w_nextBase;
            end else r_row <= r_row + ADDR_WIDTH'(1);
          end else r_col <= r_col + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine_param.sv
// Scoreboarded bench: two engines (ReLU on / off) share the same SRAM images; a record-walking
// reference model queues expected writes, and per-instance monitors pop and compare them.
module tb_conv_engine_param;

  localparam int DW = 16, AW = 12, K = 3, MAXD = 32, MEMSZ = 4096;

  logic clk = 1'b0, reset = 1'b1, dut_run = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] inMem [MEMSZ];
  logic [DW-1:0] wMem  [MEMSZ];

  logic          busyA, weA, busyB, weB;
  logic [AW-1:0] inAddrA, wAddrA, wrAddrA, inAddrB, wAddrB, wrAddrB;
  logic [DW-1:0] inDataA, wDataA, wrDataA, inDataB, wDataB, wrDataB;

  conv_engine_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .KDIM(K), .MAX_DIM(MAXD), .RELU_EN(1)) dutA (
    .clk(clk), .reset(reset), .dut_run(dut_run), .dut_busy(busyA),
    .input_sram_read_address(inAddrA), .input_sram_read_data(inDataA),
    .weights_sram_read_address(wAddrA), .weights_sram_read_data(wDataA),
    .output_sram_write_enable(weA), .output_sram_write_addresss(wrAddrA),
    .output_sram_write_data(wrDataA));

  conv_engine_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .KDIM(K), .MAX_DIM(MAXD), .RELU_EN(0)) dutB (
    .clk(clk), .reset(reset), .dut_run(dut_run), .dut_busy(busyB),
    .input_sram_read_address(inAddrB), .input_sram_read_data(inDataB),
    .weights_sram_read_address(wAddrB), .weights_sram_read_data(wDataB),
    .output_sram_write_enable(weB), .output_sram_write_addresss(wrAddrB),
    .output_sram_write_data(wrDataB));

  always @(posedge clk) begin
    inDataA <= inMem[inAddrA];
    wDataA  <= wMem[wAddrA];
    inDataB <= inMem[inAddrB];
    wDataB  <= wMem[wAddrB];
  end

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} exp_t;
  exp_t qA[$], qB[$];
  int tests = 0, fails = 0, writesA = 0, writesB = 0, fillBase = 0;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (weA === 1'b1) begin
      writesA++;
      if (qA.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpectedWriteA: got addr %0h data %0h expected no write", wrAddrA, wrDataA);
      end else begin
        e = qA.pop_front();
        checkOutput("writeAddrA", 32'(wrAddrA), 32'(e.addr));
        checkOutput("writeDataA", 32'(wrDataA), 32'(e.data));
      end
    end
    if (weB === 1'b1) begin
      writesB++;
      if (qB.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpectedWriteB: got addr %0h data %0h expected no write", wrAddrB, wrDataB);
      end else begin
        e = qB.pop_front();
        checkOutput("writeAddrB", 32'(wrAddrB), 32'(e.addr));
        checkOutput("writeDataB", 32'(wrDataB), 32'(e.data));
      end
    end
  end

  function automatic logic [DW-1:0] satVal(longint s, bit relu);
    longint v = s;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[DW-1:0];
  endfunction

  // Walk the records the way the memory layout describes them and queue every expected write.
  task automatic buildExpected(output int nOut, output int nRec);
    int base = 0, n;
    longint s;
    exp_t e;
    nOut = 0; nRec = 0;
    qA.delete(); qB.delete();
    forever begin
      n = int'(inMem[base]);
      nRec++;
      if (n == 16'hFFFF || n > MAXD) break;
      if (n >= K) begin
        for (int r = 0; r <= n - K; r++)
          for (int c = 0; c <= n - K; c++) begin
            s = 0;
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++)
                s += longint'($signed(inMem[base + 1 + (r + i) * n + c + j])) *
                     longint'($signed(wMem[i * K + j]));
            e.addr = AW'(nOut % MEMSZ);
            e.data = satVal(s, 1'b1); qA.push_back(e);
            e.data = satVal(s, 1'b0); qB.push_back(e);
            nOut++;
          end
      end
      base += 1 + n * n;
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < MEMSZ; i++) begin inMem[i] = '0; wMem[i] = '0; end
    fillBase = 0;
  endtask

  task automatic addRecord(int n, int mode, logic [DW-1:0] val);
    inMem[fillBase] = n[DW-1:0];
    for (int i = 0; i < n * n; i++)
      inMem[fillBase + 1 + i] = (mode == 0) ? val :
                                (mode == 1) ? DW'($urandom_range(0, 31)) - 16'd16 : DW'($urandom);
    fillBase += 1 + n * n;
  endtask

  task automatic setWeights(int mode, logic [DW-1:0] val);
    for (int i = 0; i < K * K; i++)
      wMem[i] = (mode == 0) ? val : (mode == 1) ? DW'($urandom_range(0, 15)) - 16'd8 : DW'($urandom);
  endtask

  task automatic applyStimulus(int id);
    clearMem();
    case (id)
      0: begin setWeights(0, 16'd1); addRecord(4, 0, 16'd1); end
      1: begin setWeights(0, 16'hFFFF); addRecord(4, 0, 16'd1); end
      2: begin setWeights(0, 16'd2); addRecord(3, 0, 16'h7FFF); end
      3: begin setWeights(0, 16'd1); addRecord(4, 0, 16'd1); addRecord(2, 0, 16'd1); addRecord(3, 0, 16'd1); end
      4: ;
      5: begin setWeights(2, 16'd0); addRecord(32, 2, 16'd0); end
      6: begin setWeights(1, 16'd0); addRecord(6, 1, 16'd0); end
      default: begin
        setWeights($urandom_range(1, 2), 16'd0);
        for (int r = 0; r < int'($urandom_range(1, 3)); r++)
          addRecord($urandom_range(0, 8), $urandom_range(1, 2), 16'd0);
      end
    endcase
    if (id == 5) inMem[fillBase] = 16'd33;
    else if (id >= 7 && $urandom_range(0, 2) == 0) inMem[fillBase] = DW'($urandom_range(33, 65534));
    else inMem[fillBase] = 16'hFFFF;
  endtask

  task automatic runAndCheck(string name);
    int startA = writesA, startB = writesB, expN, nRec, limit, busyCycles = 0;
    bit done = 1'b0;
    buildExpected(expN, nRec);
    limit = 30 + nRec * 6 + expN * (K * K + 3);
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (!busyA) begin done = 1'b1; break; end
      busyCycles++;
      @(negedge clk);
    end
    checkOutput({name, "_busyRose"}, 32'(busyCycles > 0), 32'd1);
    if (!done) begin
      tests++; fails++;
      $display("[TB] FAIL %s_timeout: got busy after %0d cycles expected idle", name, limit);
      while (busyA) @(negedge clk);
    end
    checkOutput({name, "_writesA"}, 32'(writesA - startA), 32'(expN));
    checkOutput({name, "_writesB"}, 32'(writesB - startB), 32'(expN));
    checkOutput({name, "_busyB"}, 32'(busyB), 32'd0);
  endtask

  task automatic waitBusy(string name, logic level, int limit);
    bit seen = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (busyA == level) begin seen = 1'b1; break; end
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int target;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busyA), 32'd0);
    checkOutput("reset_we", 32'(weA), 32'd0);
    checkOutput("reset_inAddr", 32'(inAddrA), 32'd0);
    checkOutput("reset_wAddr", 32'(wAddrA), 32'd0);
    checkOutput("reset_wrAddr", 32'(wrAddrA), 32'd0);
    checkOutput("reset_wrData", 32'(wrDataA), 32'd0);
    @(negedge clk) reset = 1'b0;

    applyStimulus(0); runAndCheck("allOnes");
    applyStimulus(1); runAndCheck("negWeights");
    applyStimulus(2); runAndCheck("saturate");
    applyStimulus(3); runAndCheck("skipRecord");
    applyStimulus(4); runAndCheck("sentinelOnly");
    for (int t = 0; t < 8; t++) begin
      applyStimulus(7 + t); runAndCheck("random");
    end
    applyStimulus(5); runAndCheck("maxDim");

    // Run request held high: the engine must come back to IDLE and start again.
    applyStimulus(4);
    @(negedge clk) dut_run = 1'b1;
    waitBusy("runHeld_fall", 1'b0, 60);
    waitBusy("runHeld_restart", 1'b1, 3);
    dut_run = 1'b0;
    waitBusy("runHeld_idle", 1'b0, 60);

    // Reset in the middle of a convolution, then rerun from scratch.
    applyStimulus(6);
    buildExpected(target, target);
    target = writesA + 3;
    @(negedge clk) dut_run = 1'b1;
    @(negedge clk) dut_run = 1'b0;
    for (int c = 0; c < 200 && writesA < target; c++) @(negedge clk);
    checkOutput("midReset_reachedConv", 32'(writesA >= target), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midReset_busyA", 32'(busyA), 32'd0);
    checkOutput("midReset_weA", 32'(weA), 32'd0);
    checkOutput("midReset_busyB", 32'(busyB), 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    qA.delete(); qB.delete();
    runAndCheck("afterReset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
